// File: rtl/tlb_pkg.sv
// tlb_pkg: MMU constants and the TLB entry layout shared by the TLB and the address translator
package tlb_pkg;
  localparam int TLBNUM = 16;
  localparam int VPN2W = 19;
  localparam int PFNW = 20;
  localparam int ASIDW = 8;
  localparam int CW = 3;
  localparam logic [CW-1:0] CACHED = 3'h3;
  typedef struct packed {
    logic [VPN2W-1:0] vpn2;
    logic [ASIDW-1:0] asid;
    logic g;
    logic [PFNW-1:0] pfn0;
    logic [CW-1:0] c0;
    logic d0;
    logic v0;
    logic [PFNW-1:0] pfn1;
    logic [CW-1:0] c1;
    logic d1;
    logic v1;
  } tlb_entry_t;
endpackage

// File: rtl/tlb_if.sv
// tlb_if: lookup ports s0/s1, shared asid, write port, read port and Wired/Random signals of the TLB
// master drives keys, writes, r_index and wired; slave (the TLB) returns lookup/read results and random
interface tlb_if import tlb_pkg::*; #(parameter int IDXW = 4);
  logic [VPN2W-1:0] s0_vpn2, s1_vpn2;
  logic s0_odd_page, s1_odd_page;
  logic s0_found, s1_found;
  logic [IDXW-1:0] s0_index, s1_index;
  logic [PFNW-1:0] s0_pfn, s1_pfn;
  logic [CW-1:0] s0_c, s1_c;
  logic s0_d, s1_d, s0_v, s1_v;
  logic [ASIDW-1:0] asid;
  logic we;
  logic [IDXW-1:0] w_index;
  logic [VPN2W-1:0] w_vpn2;
  logic [ASIDW-1:0] w_asid;
  logic w_g;
  logic [PFNW-1:0] w_pfn0, w_pfn1;
  logic [CW-1:0] w_c0, w_c1;
  logic w_d0, w_d1, w_v0, w_v1;
  logic [IDXW-1:0] r_index;
  logic [VPN2W-1:0] r_vpn2;
  logic [ASIDW-1:0] r_asid;
  logic r_g;
  logic [PFNW-1:0] r_pfn0, r_pfn1;
  logic [CW-1:0] r_c0, r_c1;
  logic r_d0, r_d1, r_v0, r_v1;
  logic [IDXW-1:0] wired, random;
  logic wired_we;
  modport master (
    output s0_vpn2, s0_odd_page, s1_vpn2, s1_odd_page, asid,
    output we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    output r_index, wired, wired_we,
    input s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    input s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    input r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1, random
  );
  modport slave (
    input s0_vpn2, s0_odd_page, s1_vpn2, s1_odd_page, asid,
    input we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    input r_index, wired, wired_we,
    output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1, random
  );
endinterface

// File: rtl/tlb_match.sv
// tlb_match: one combinational lookup port -- compare all entries, lowest index wins, pick odd/even half
// in: ent_i (all entries), vpn2_i, odd_i, asid_i; out: found_o, index_o, pfn_o, c_o, d_o, v_o (zero on miss)
module tlb_match import tlb_pkg::*; #(
  parameter int TLBNUM = 16,
  parameter int IDXW = 4
) (
  input tlb_entry_t ent_i [TLBNUM],
  input logic [VPN2W-1:0] vpn2_i,
  input logic odd_i,
  input logic [ASIDW-1:0] asid_i,
  output logic found_o,
  output logic [IDXW-1:0] index_o,
  output logic [PFNW-1:0] pfn_o,
  output logic [CW-1:0] c_o,
  output logic d_o,
  output logic v_o
);
  tlb_entry_t sel;
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    // scanning downward lets the lowest matching index overwrite higher ones
    for (int i = TLBNUM - 1; i >= 0; i--)
      if (ent_i[i].vpn2 == vpn2_i && (ent_i[i].g || ent_i[i].asid == asid_i)) begin
        found_o = 1'b1;
        index_o = IDXW'(i);
      end
    sel = ent_i[index_o];
    pfn_o = !found_o ? '0 : odd_i ? sel.pfn1 : sel.pfn0;
    c_o = !found_o ? '0 : odd_i ? sel.c1 : sel.c0;
    d_o = found_o && (odd_i ? sel.d1 : sel.d0);
    v_o = found_o && (odd_i ? sel.v1 : sel.v0);
  end
endmodule

// File: rtl/tlb.sv
// tlb: TLBNUM-entry MIPS-style TLB with two combinational lookup ports, TLBWI/TLBWR write, TLBR read and CP0 Random
// ports: clk, resetn (sync, active-low), bus (tlb_if.slave: s0/s1 lookups, write, read, wired/wired_we/random)
module tlb import tlb_pkg::*; #(
  parameter int TLBNUM = tlb_pkg::TLBNUM,
  parameter int IDXW = 4
) (
  input logic clk,
  input logic resetn,
  tlb_if.slave bus
);
  localparam logic [IDXW-1:0] LAST = IDXW'(TLBNUM - 1);
  tlb_entry_t ent_q [TLBNUM];
  tlb_entry_t w_ent, r_ent;
  logic [IDXW-1:0] random_q, random_d;
  assign w_ent = '{vpn2: bus.w_vpn2, asid: bus.w_asid, g: bus.w_g,
                   pfn0: bus.w_pfn0, c0: bus.w_c0, d0: bus.w_d0, v0: bus.w_v0,
                   pfn1: bus.w_pfn1, c1: bus.w_c1, d1: bus.w_d1, v1: bus.w_v1};
  // wired beyond the last index cannot be reached by decrementing, so random parks at LAST
  assign random_d = (bus.wired_we || random_q == bus.wired || bus.wired > LAST) ? LAST : random_q - 1'b1;
  always_ff @(posedge clk)
    if (!resetn) begin
      random_q <= LAST;
      for (int i = 0; i < TLBNUM; i++) begin
        ent_q[i].v0 <= 1'b0;
        ent_q[i].v1 <= 1'b0;
        ent_q[i].g <= 1'b0;
      end
    end else begin
      random_q <= random_d;
      if (bus.we) ent_q[bus.w_index] <= w_ent;
    end
  assign bus.random = random_q;
  assign r_ent = ent_q[bus.r_index];
  assign {bus.r_vpn2, bus.r_asid, bus.r_g, bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0,
          bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1} = r_ent;
  tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_s0 (
    .ent_i(ent_q), .vpn2_i(bus.s0_vpn2), .odd_i(bus.s0_odd_page), .asid_i(bus.asid),
    .found_o(bus.s0_found), .index_o(bus.s0_index), .pfn_o(bus.s0_pfn),
    .c_o(bus.s0_c), .d_o(bus.s0_d), .v_o(bus.s0_v)
  );
  tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_s1 (
    .ent_i(ent_q), .vpn2_i(bus.s1_vpn2), .odd_i(bus.s1_odd_page), .asid_i(bus.asid),
    .found_o(bus.s1_found), .index_o(bus.s1_index), .pfn_o(bus.s1_pfn),
    .c_o(bus.s1_c), .d_o(bus.s1_d), .v_o(bus.s1_v)
  );
endmodule

// File: tb/tb_tlb.sv
// tb_tlb: self-checking bench for tlb -- directed vectors, write-cycle/reset corner cases and randomized traffic vs a model
module tb_tlb;
  import tlb_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  tlb_if #(.IDXW(4)) bus();
  tlb #(.TLBNUM(16), .IDXW(4)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  typedef struct packed {
    logic found;
    logic [3:0] idx;
    logic [19:0] pfn;
    logic [2:0] c;
    logic d;
    logic v;
  } res_t;
  typedef struct {
    logic [18:0] vpn2;
    logic odd;
    logic [7:0] asid;
    res_t exp;
  } vec_t;
  tlb_entry_t m [16];
  logic [3:0] mrand;
  int nchk = 0;
  int nfail = 0;
  vec_t tv [6];
  function automatic res_t ref_lookup(logic [18:0] vpn2, logic odd, logic [7:0] asid);
    res_t r = '0;
    for (int i = 0; i < 16; i++)
      if (m[i].vpn2 == vpn2 && (m[i].g || m[i].asid == asid)) begin
        r.found = 1'b1;
        r.idx = 4'(i);
        r.pfn = odd ? m[i].pfn1 : m[i].pfn0;
        r.c = odd ? m[i].c1 : m[i].c0;
        r.d = odd ? m[i].d1 : m[i].d0;
        r.v = odd ? m[i].v1 : m[i].v0;
        return r;
      end
    return r;
  endfunction
  function automatic res_t s0r();
    return {bus.s0_found, bus.s0_index, bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v};
  endfunction
  function automatic res_t s1r();
    return {bus.s1_found, bus.s1_index, bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v};
  endfunction
  function automatic tlb_entry_t rd();
    return {bus.r_vpn2, bus.r_asid, bus.r_g, bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0,
            bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1};
  endfunction
  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (!resetn) begin
      for (int i = 0; i < 16; i++) begin
        m[i].v0 = 1'b0;
        m[i].v1 = 1'b0;
        m[i].g = 1'b0;
      end
      mrand = 4'd15;
    end else begin
      if (bus.we)
        m[bus.w_index] = {bus.w_vpn2, bus.w_asid, bus.w_g, bus.w_pfn0, bus.w_c0, bus.w_d0, bus.w_v0,
                          bus.w_pfn1, bus.w_c1, bus.w_d1, bus.w_v1};
      mrand = (bus.wired_we || mrand == bus.wired || bus.wired > 4'd15) ? 4'd15 : 4'(mrand - 1);
    end
    #1;
  endtask
  task automatic set_w(input logic [3:0] idx, input tlb_entry_t e);
    bus.w_index = idx;
    {bus.w_vpn2, bus.w_asid, bus.w_g, bus.w_pfn0, bus.w_c0, bus.w_d0, bus.w_v0,
     bus.w_pfn1, bus.w_c1, bus.w_d1, bus.w_v1} = e;
  endtask
  task automatic wr(input logic [3:0] idx, input tlb_entry_t e);
    set_w(idx, e);
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
  endtask
  task automatic key(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    bus.s0_vpn2 = vpn2;
    bus.s1_vpn2 = vpn2;
    bus.s0_odd_page = odd;
    bus.s1_odd_page = odd;
    bus.asid = asid;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tlb_entry_t e;
    key('0, 1'b0, '0);
    bus.we = 1'b0;
    set_w('0, '0);
    bus.r_index = '0;
    bus.wired = 4'd3;
    bus.wired_we = 1'b0;
    mrand = '0;
    for (int i = 0; i < 16; i++) m[i] = '0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rst_random", bus.random, 15);
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk("random_seq", bus.random, (k < 13) ? 15 - k : 15);
    end
    for (int k = 0; k < 20 && bus.random != 4'd7; k++) tick();
    chk("random_at7", bus.random, 7);
    bus.wired_we = 1'b1;
    tick();
    bus.wired_we = 1'b0;
    chk("wired_we_reload", bus.random, 15);
    bus.wired = 4'd15;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wired_last_hold", bus.random, 15);
    end
    bus.wired = 4'd0;
    for (int i = 0; i < 16; i++) begin
      e = {19'h70000 | 19'(i), 8'(i), 1'b0, 20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
           20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom)};
      wr(4'(i), e);
    end
    wr(4'd5, {19'h00123, 8'h10, 1'b0, 20'h00A00, 3'd3, 1'b0, 1'b1, 20'h00A01, 3'd3, 1'b1, 1'b1});
    wr(4'd2, {19'h00456, 8'h20, 1'b0, 20'h00111, 3'd2, 1'b1, 1'b1, 20'h00222, 3'd3, 1'b0, 1'b0});
    wr(4'd9, {19'h00456, 8'h20, 1'b0, 20'h00999, 3'd2, 1'b1, 1'b1, 20'h00998, 3'd3, 1'b0, 1'b0});
    tv[0] = '{19'h00123, 1'b1, 8'h10, {1'b1, 4'd5, 20'h00A01, 3'd3, 1'b1, 1'b1}};
    tv[1] = '{19'h00123, 1'b0, 8'h10, {1'b1, 4'd5, 20'h00A00, 3'd3, 1'b0, 1'b1}};
    tv[2] = '{19'h00123, 1'b1, 8'h11, 30'd0};
    tv[3] = '{19'h00456, 1'b0, 8'h20, {1'b1, 4'd2, 20'h00111, 3'd2, 1'b1, 1'b1}};
    tv[4] = '{19'h00456, 1'b1, 8'h20, {1'b1, 4'd2, 20'h00222, 3'd3, 1'b0, 1'b0}};
    tv[5] = '{19'h00456, 1'b1, 8'h21, 30'd0};
    for (int i = 0; i < 6; i++) begin
      key(tv[i].vpn2, tv[i].odd, tv[i].asid);
      #1;
      chk($sformatf("vec%0d_s0", i), s0r(), tv[i].exp);
      chk($sformatf("vec%0d_s1", i), s1r(), tv[i].exp);
    end
    bus.r_index = 4'd5;
    #1;
    chk("read5_pfn1", bus.r_pfn1, 20'h00A01);
    chk("read5_g", bus.r_g, 0);
    key(19'h00123, 1'b1, 8'h11);
    set_w(4'd5, {19'h00123, 8'h10, 1'b1, 20'h00A00, 3'd3, 1'b0, 1'b1, 20'h00A01, 3'd3, 1'b1, 1'b1});
    bus.we = 1'b1;
    #1;
    chk("wcycle_s1_old", s1r(), 30'd0);
    chk("wcycle_read_old", bus.r_g, 0);
    tick();
    bus.we = 1'b0;
    #1;
    chk("after_w_s1_global", s1r(), {1'b1, 4'd5, 20'h00A01, 3'd3, 1'b1, 1'b1});
    chk("after_w_read_g", bus.r_g, 1);
    for (int k = 0; k < 400; k++) begin
      bus.we = ($urandom % 3 == 0);
      set_w(4'($urandom), {19'h00100 + 19'($urandom % 4), 8'($urandom % 2 + 1), 1'($urandom % 4 == 0),
                           20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                           20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom)});
      bus.s0_vpn2 = 19'h00100 + 19'($urandom % 4);
      bus.s1_vpn2 = ($urandom % 8 == 0) ? 19'h00456 : 19'h00100 + 19'($urandom % 4);
      bus.s0_odd_page = 1'($urandom);
      bus.s1_odd_page = 1'($urandom);
      bus.asid = ($urandom % 6 == 0) ? 8'h20 : 8'($urandom % 2 + 1);
      bus.r_index = 4'($urandom);
      if (k % 16 == 0) bus.wired = 4'($urandom);
      bus.wired_we = ($urandom % 20 == 0);
      #1;
      chk("rand_s0", s0r(), ref_lookup(bus.s0_vpn2, bus.s0_odd_page, bus.asid));
      chk("rand_s1", s1r(), ref_lookup(bus.s1_vpn2, bus.s1_odd_page, bus.asid));
      chk("rand_read", rd(), m[bus.r_index]);
      chk("rand_random", bus.random, mrand);
      tick();
    end
    bus.we = 1'b0;
    bus.wired_we = 1'b0;
    bus.wired = 4'd0;
    set_w(4'd0, {19'h55555, 8'h33, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h54321, 3'd3, 1'b1, 1'b1});
    bus.we = 1'b1;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    bus.we = 1'b0;
    bus.r_index = 4'd0;
    bus.s0_vpn2 = m[0].vpn2;
    bus.s0_odd_page = 1'b1;
    bus.asid = m[0].asid;
    bus.s1_vpn2 = 19'h55555;
    bus.s1_odd_page = 1'b0;
    #1;
    chk("rstw_v0", bus.r_v0, 0);
    chk("rstw_v1", bus.r_v1, 0);
    chk("rstw_g", bus.r_g, 0);
    chk("rstw_random", bus.random, 15);
    chk("rstw_vpn2_kept", bus.r_vpn2, m[0].vpn2);
    chk("stale_found", bus.s0_found, 1);
    chk("stale_index", bus.s0_index, 0);
    chk("stale_v", bus.s0_v, 0);
    chk("discarded_write_miss", s1r(), 30'd0);
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end
endmodule
